// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared types and helpers for the dual-port RAM with clear sequencer.
//   clr_state_t : clear sequencer states (IDLE / CLEAR / DONE)
//   rd_sel_t    : source of the registered read data (zero / array / bypass)
//   addr_in_range : address-vs-depth check used on both ports
//   depth_fits    : elaboration-time sanity helper for DEPTH vs ADDR_W
// ---------------------------------------------------------------------------
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  typedef enum logic [1:0] {
    RD_ZERO = 2'd0,
    RD_MEM  = 2'd1,
    RD_BYP  = 2'd2
  } rd_sel_t;

  // True when addr selects a physically present word. Non-power-of-two
  // depths leave a hole at the top of the address space that must be masked.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] depth);
    return (addr < depth);
  endfunction

  function automatic bit depth_fits(input int depth, input int addr_w);
    return (depth > 0) && (longint'(depth) <= (longint'(1) << addr_w));
  endfunction

endpackage

// File: rtl/ram_dp_core.sv
// ---------------------------------------------------------------------------
// ram_dp_core
// Plain storage array: one synchronous write port and one synchronous read
// port on the same clock. No reset and no gating so that synthesis maps it
// straight onto block RAM. Read-before-write on a same-address access (the
// read returns the old contents).
//   clk_i  : clock
//   we_i   : write enable
//   wa_i   : write address (must be < DEPTH when we_i is high)
//   wd_i   : write data
//   ra_i   : read address  (must be < DEPTH)
//   rd_o   : registered read data, valid one cycle after ra_i
// ---------------------------------------------------------------------------
module ram_dp_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 129072
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [ADDR_W-1:0] ra_i,
  output logic [DATA_W-1:0] rd_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[wa_i] <= wd_i;
    end
    rd_q <= mem[ra_i];
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/ram_dp_clr.sv
// ---------------------------------------------------------------------------
// ram_dp_clr
// Single-clock dual-port RAM (one write, one read) with a hardware clear
// sequencer, read-during-write control and out-of-range address masking.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset (array contents are kept)
//   wa/wd/we : write port; dropped when wa >= DEPTH or while clearing
//   ra/re    : read port; rd is zero one cycle after re=0, ra >= DEPTH,
//              or any read issued while clearing
//   rd       : read data, one cycle latency
//   clr_req  : one-cycle pulse that starts a clear sweep (ignored in CLEAR)
//   clr_busy : high while the sweep writes CLEAR_VAL, exactly DEPTH cycles
//   clr_done : one-cycle pulse after the last word is cleared
// ---------------------------------------------------------------------------
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 17,
  parameter int                DEPTH          = 129072,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0,
  parameter int                CLEAR_ON_RESET = 1,
  parameter int                RDW_NEW        = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              we,
  input  logic [ADDR_W-1:0] ra,
  input  logic              re,
  output logic [DATA_W-1:0] rd,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam bit                DEPTH_OK  = depth_fits(DEPTH, ADDR_W);

  // -------------------------------------------------------------------------
  // Clear sequencer
  // -------------------------------------------------------------------------
  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  // Pending automatic start; set by reset so the sweep begins on the first
  // clock after reset_n rises.
  logic              init_q, init_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      init_q  <= (CLEAR_ON_RESET != 0) && DEPTH_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (init_q || clr_req) begin
          state_d = CLEAR;
          init_d  = 1'b0;
        end
      end
      CLEAR: begin
        // Terminal compare on DEPTH-1 keeps the counter inside the array
        // even when DEPTH is not a power of two.
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = clr_req ? CLEAR : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic sweeping;
  assign sweeping = (state_q == CLEAR);
  assign clr_busy = sweeping;
  assign clr_done = (state_q == DONE);

  // -------------------------------------------------------------------------
  // Address range checks and write-port mux
  // -------------------------------------------------------------------------
  logic              wa_ok, ra_ok;
  logic              core_we;
  logic [ADDR_W-1:0] core_wa, core_ra;
  logic [DATA_W-1:0] core_wd, core_rd;

  assign wa_ok = addr_in_range(32'(wa), 32'(DEPTH));
  assign ra_ok = addr_in_range(32'(ra), 32'(DEPTH));

  // The sweep owns the write port while clearing; external writes are lost.
  assign core_we = sweeping | (we & wa_ok);
  assign core_wa = sweeping ? cnt_q : wa;
  assign core_wd = sweeping ? CLEAR_VAL : wd;
  // Keep the array index legal for invalid reads; the result is discarded.
  assign core_ra = ra_ok ? ra : '0;

  ram_dp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk_i (clk),
    .we_i  (core_we),
    .wa_i  (core_wa),
    .wd_i  (core_wd),
    .ra_i  (core_ra),
    .rd_o  (core_rd)
  );

  // -------------------------------------------------------------------------
  // Read-data source select, bypass register and output gating
  // -------------------------------------------------------------------------
  rd_sel_t           rd_sel_q, rd_sel_d;
  logic [DATA_W-1:0] byp_q;

  always_comb begin
    rd_sel_d = RD_ZERO;
    if (re && ra_ok && !sweeping) begin
      // The core is read-before-write, so old-data collisions need nothing
      // extra; new-data collisions take the write data through byp_q.
      if ((RDW_NEW != 0) && we && (wa == ra)) begin
        rd_sel_d = RD_BYP;
      end else begin
        rd_sel_d = RD_MEM;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sel_q <= RD_ZERO;
    end else begin
      rd_sel_q <= rd_sel_d;
    end
  end

  // Data-only register: its value is only visible when rd_sel_q says so.
  always_ff @(posedge clk) begin
    if (rd_sel_d == RD_BYP) begin
      byp_q <= wd;
    end
  end

  always_comb begin
    rd = '0;
    unique case (rd_sel_q)
      RD_MEM:  rd = core_rd;
      RD_BYP:  rd = byp_q;
      default: rd = '0;
    endcase
  end

endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
- Parametrised single-clock dual-port RAM (one write port, one read port) for video, program and playfield buffers.
- Keeps the existing gated-read behaviour: the output is zero when the read enable is low.
- Adds a hardware clear sequencer that sweeps every word to CLEAR_VAL after reset or on request.
- Adds read-during-write collision control and out-of-range address protection, so non-power-of-two depths are safe.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 17, address width in bits.
- DEPTH, 129072, number of words; must satisfy DEPTH <= 2**ADDR_W.
- CLEAR_VAL, 0, DATA_W-bit value written by the clear sequencer.
- CLEAR_ON_RESET, 1, 1 = start a clear sweep automatically when reset deasserts.
- RDW_NEW, 1, same-address read and write in one cycle: 1 = return the new data, 0 = return the old data.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- we  in  1  write enable.
- ra  in  ADDR_W  read address.
- re  in  1  read enable.
- rd  out  DATA_W  registered read data.
- clr_req  in  1  one-cycle pulse that starts a clear sweep.
- clr_busy  out  1  high while the sweep runs.
- clr_done  out  1  one-cycle pulse after the last word is cleared.

Behaviour:
- Reset (async, reset_n low):
  - rd = 0, clr_busy = 0, clr_done = 0.
  - Sweep counter = 0.
  - FSM = IDLE.
  - Array contents are not reset.
- FSM states are IDLE, CLEAR and DONE.
  - IDLE -> CLEAR: on the first clock after reset_n rises if CLEAR_ON_RESET=1, otherwise on clr_req=1.
  - CLEAR: writes CLEAR_VAL to address cnt and increments cnt, one word per cycle.
  - CLEAR -> DONE: when cnt == DEPTH-1 has been written.
  - DONE: lasts one cycle, clr_done = 1, then -> IDLE.
  - clr_busy = 1 exactly while in CLEAR, so the sweep takes DEPTH cycles.
- During CLEAR:
  - External writes (we) are dropped.
  - re is honoured, but rd = 0 in the cycle after any read.
  - clr_req is ignored.
- clr_req in DONE or IDLE starts a new sweep the next cycle.
- Write port (IDLE/DONE): if we=1 and wa < DEPTH, mem[wa] <= wd at the clock edge. If wa >= DEPTH the write is silently dropped.
- Read port, 1-cycle latency, at each edge:
  - re=0 -> rd <= 0.
  - re=1 and ra >= DEPTH -> rd <= 0.
  - re=1 and ra valid -> rd <= mem[ra].
- Collision (re=1, we=1, ra==wa, valid address, not CLEAR):
  - RDW_NEW=1 -> rd <= wd, via a bypass mux.
  - RDW_NEW=0 -> rd <= previous contents.
- Reset mid-sweep:
  - Sweep aborts and cnt returns to 0.
  - If CLEAR_ON_RESET=1 the sweep restarts from address 0 after reset_n rises.
  - Partially cleared contents are otherwise left as-is.
- Counter width is ADDR_W. The terminal compare is against DEPTH-1, so the counter never wraps past DEPTH.

Decomposition:
- Shared package ram_pkg:
  - clr_state_t enum {IDLE, CLEAR, DONE}.
  - Localparam helper for the address range check.
- Sub-module ram_dp_core: pure inferable storage with one sync write and one sync read, no reset, no gating. It keeps block-RAM inference clean.
- ram_dp_clr holds the FSM, the write-port mux (sweep vs external), range checks, the bypass register and the output gating.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=16 -> clr_busy high for exactly 16 cycles; clr_done pulses once on cycle 17. Then reading addresses 0..15 with re=1 gives rd=0x00 each, one cycle after ra.
- Write 0xA5 to address 3, then read address 3 with re=1 -> rd=0xA5 after 1 cycle. Same read with re=0 -> rd=0x00.
- Same-cycle we=1/re=1 at address 5 (old 0x11, new 0x22) -> rd=0x22 with RDW_NEW=1 and rd=0x11 with RDW_NEW=0. A following read of address 5 -> 0x22.
- DEPTH=12, ADDR_W=4:
  - Write 0x77 to address 13 -> dropped; no alias at addresses 0..11.
  - Read address 13 -> rd=0x00.
- clr_req after filling with 0xFF; we=1 to address 2 with 0x55 during the sweep -> write dropped; all words read 0x00 after clr_done. A second clr_req mid-sweep does not extend clr_busy.
- Assert reset_n low at sweep cycle 7 of 16 -> rd, clr_busy and clr_done go to 0 immediately (async). After release the sweep restarts at 0 and runs a full 16 cycles.
